// File: rtl/ctrl_seq.sv
// ctrl_seq: T-state sequencer and control-strobe decoder for an 8-bit accumulator CPU
`ifndef WORDSIZE
`define WORDSIZE 8
`endif
module ctrl_seq #(
   parameter int OPW = 4
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 run,
   input  logic [`WORDSIZE-1:0] instr,
   output logic                 pc_oe,
   output logic                 pc_inc,
   output logic                 mar_ld,
   output logic                 ram_oe,
   output logic                 ir_ld,
   output logic                 ir_oe,
   output logic                 a_ld,
   output logic                 a_oe,
   output logic                 b_ld,
   output logic                 alu_oe,
   output logic                 alu_sub,
   output logic                 out_ld,
   output logic [5:0]           tstate,
   output logic                 halted,
   output logic [`WORDSIZE-1:0] icount
);
   typedef enum logic [2:0] {IDLE, T1, T2, T3, T4, T5, T6, HALT} state_t;
   localparam logic [OPW-1:0] OP_LDA = OPW'(0);
   localparam logic [OPW-1:0] OP_ADD = OPW'(1);
   localparam logic [OPW-1:0] OP_SUB = OPW'(2);
   localparam logic [OPW-1:0] OP_OUT = OPW'(14);
   localparam logic [OPW-1:0] OP_HLT = '1;
   state_t         state;
   logic [OPW-1:0] op;
   logic           unused_operand;
   logic           lda, alu, sub, outi, mem;
   assign op             = instr[`WORDSIZE-1 -: OPW];
   assign unused_operand = ^instr[`WORDSIZE-OPW-1:0];
   assign lda  = op == OP_LDA;
   assign sub  = op == OP_SUB;
   assign alu  = (op == OP_ADD) || sub;
   assign outi = op == OP_OUT;
   assign mem  = lda || alu;
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= IDLE;
         icount <= '0;
      end else begin
         case (state)
            IDLE:    state <= run ? T1 : IDLE;
            T1:      state <= T2;
            T2:      state <= T3;
            T3:      state <= T4;
            T4:      state <= (op == OP_HLT) ? HALT : T5;
            T5:      state <= T6;
            T6: begin
               state  <= run ? T1 : IDLE;
               icount <= icount + 1'b1;
            end
            default: state <= HALT;
         endcase
      end
   end
   assign tstate  = {state == T6, state == T5, state == T4, state == T3, state == T2, state == T1};
   assign halted  = state == HALT;
   // execute-phase strobes follow instr live; fetch strobes ignore it
   assign pc_oe   = state == T1;
   assign pc_inc  = state == T2;
   assign mar_ld  = (state == T1) || (state == T4 && mem);
   assign ram_oe  = (state == T3) || (state == T5 && mem);
   assign ir_ld   = state == T3;
   assign ir_oe   = state == T4 && mem;
   assign a_ld    = (state == T5 && lda) || (state == T6 && alu);
   assign a_oe    = state == T4 && outi;
   assign b_ld    = state == T5 && alu;
   assign alu_oe  = state == T6 && alu;
   assign alu_sub = state == T6 && sub;
   assign out_ld  = state == T4 && outi;
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed and randomized checks of ctrl_seq against a step-count reference model
module tb_ctrl_seq;
   logic       clk = 1'b0, clr = 1'b1, run = 1'b0;
   logic [7:0] instr = 8'h00;
   logic pc_oe, pc_inc, mar_ld, ram_oe, ir_ld, ir_oe, a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld, halted;
   logic [5:0] tstate;
   logic [7:0] icount;
   int checks = 0, passes = 0, fails = 0;
   int t = 0;
   int cnt = 0;
   localparam logic [11:0] PC_OE = 12'h800, PC_INC = 12'h400, MAR_LD = 12'h200, RAM_OE = 12'h100,
                           IR_LD = 12'h080, IR_OE = 12'h040, A_LD = 12'h020, A_OE = 12'h010,
                           B_LD = 12'h008, ALU_OE = 12'h004, ALU_SUB = 12'h002, OUT_LD = 12'h001;

   ctrl_seq #(.OPW(4)) dut (
      .clk(clk), .clr(clr), .run(run), .instr(instr),
      .pc_oe(pc_oe), .pc_inc(pc_inc), .mar_ld(mar_ld), .ram_oe(ram_oe), .ir_ld(ir_ld), .ir_oe(ir_oe),
      .a_ld(a_ld), .a_oe(a_oe), .b_ld(b_ld), .alu_oe(alu_oe), .alu_sub(alu_sub), .out_ld(out_ld),
      .tstate(tstate), .halted(halted), .icount(icount)
   );

   always #5 clk = ~clk;

   // t: 0 idle, 1..6 T-state number, 7 halted
   function automatic logic [11:0] exp_strobes(input int tt, input logic [3:0] op);
      case (tt)
         1: return PC_OE | MAR_LD;
         2: return PC_INC;
         3: return RAM_OE | IR_LD;
         4: return (op <= 4'd2) ? (IR_OE | MAR_LD) : (op == 4'he) ? (A_OE | OUT_LD) : 12'h000;
         5: return (op == 4'd0) ? (RAM_OE | A_LD) : (op == 4'd1 || op == 4'd2) ? (RAM_OE | B_LD) : 12'h000;
         6: return (op == 4'd1 || op == 4'd2) ? (ALU_OE | A_LD | ((op == 4'd2) ? ALU_SUB : 12'h000)) : 12'h000;
         default: return 12'h000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h at %0t", name, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("strobes", {pc_oe, pc_inc, mar_ld, ram_oe, ir_ld, ir_oe, a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld},
          exp_strobes(t, instr[7:4]));
      chk("tstate", tstate, (t >= 1 && t <= 6) ? (6'd1 << (t - 1)) : 6'd0);
      chk("halted", halted, t == 7);
      chk("icount", icount, cnt);
      chk("oe_excl", $countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) <= 1, 1);
   endtask

   task automatic step(input logic r, input logic [7:0] ins);
      run = r;
      instr = ins;
      #1 check_all();
      @(posedge clk);
      case (t)
         0:       t = r ? 1 : 0;
         4:       t = (ins[7:4] == 4'hf) ? 7 : 5;
         6: begin
            cnt = (cnt + 1) % 256;
            t = r ? 1 : 0;
         end
         7:       t = 7;
         default: t = t + 1;
      endcase
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b1;
      #1 t = 0;
      cnt = 0;
      check_all();
      @(posedge clk);
      #1 clr = 1'b0;
   endtask

   task automatic pulse_clr();
      #2 clr = 1'b1;
      #1 t = 0;
      cnt = 0;
      check_all();
      #1 clr = 1'b0;
   endtask

   function automatic logic [7:0] rand_instr();
      int sel = $urandom_range(0, 9);
      logic [3:0] lo = 4'($urandom);
      case (sel)
         0, 1:    return {4'h0, lo};
         2, 3:    return {4'h1, lo};
         4:       return {4'h2, lo};
         5:       return {4'he, lo};
         6, 7:    return {4'($urandom_range(3, 13)), lo};
         8:       return ($urandom_range(0, 3) == 0) ? {4'hf, lo} : {4'h2, lo};
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      #1 do_reset();
      // LDA then ADD then SUB back to back
      for (int i = 0; i < 7; i++) step(1'b1, 8'h05);
      for (int i = 0; i < 6; i++) step(1'b1, 8'h1a);
      for (int i = 0; i < 6; i++) step(1'b1, 8'h2b);
      chk("icount_after_3", icount, 8'd3);
      // OUT then HLT, then hold in HALT
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b1, 8'he0);
      for (int i = 0; i < 4; i++) step(1'b1, 8'hf0);
      for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom));
      chk("halt_hold", {halted, tstate, icount}, {1'b1, 6'd0, 8'd1});
      // clr while halted, then run dropped during T3 of LDA
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 8'h07);
      for (int i = 0; i < 6; i++) step(1'b0, 8'h07);
      chk("run_drop_idle", {tstate, icount}, {6'd0, 8'd1});
      // async clr in T5 of ADD, then restart
      for (int i = 0; i < 5; i++) step(1'b1, 8'h13);
      pulse_clr();
      for (int i = 0; i < 8; i++) step(1'b1, 8'h13);
      // randomized run/instr with occasional clr
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (t == 7 && $urandom_range(0, 3) == 0) do_reset();
         else if ($urandom_range(0, 60) == 0) pulse_clr();
         step($urandom_range(0, 7) != 0, rand_instr());
      end
      // 256 LDAs wrap icount
      do_reset();
      step(1'b1, 8'h01);
      for (int i = 0; i < 255 * 6; i++) step(1'b1, 8'h01);
      chk("icount_255", icount, 8'd255);
      for (int i = 0; i < 6; i++) step(1'b1, 8'h01);
      chk("icount_wrap", icount, 8'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
